// File: rtl/fetcher_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetcher_pkg;

    localparam int unsigned IqDepthDefault = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StDrain = 2'd2
    } fet_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetcher_queue.sv
// In-order {pc, instr} queue between fetch and decode; circular, with synchronous flush.
module fetcher_queue
    import fetcher_pkg::*;
#(
    parameter int unsigned Depth = IqDepthDefault
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      flush_i,
    input  iq_entry_t data_i,
    output iq_entry_t data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    iq_entry_t       mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // A pop frees the slot being written, so push is legal when full if popping too.
    assign do_push = push_i && !flush_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !flush_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fetcher.sv
// Fetch stage: owns the PC, requests from ICACHE, queues {pc, instr} for decode and
// applies redirects without disturbing an outstanding ICACHE fill.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int unsigned IQ_DEPTH = IqDepthDefault,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic [31:0] pc,
    output logic        rdy_from_fet,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic        jump_flag,
    input  logic [31:0] jump_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    fet_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic      q_full, q_empty;
    logic      q_push, q_pop, q_flush;
    logic      cap, miss;
    iq_entry_t q_head;

    assign rdy_from_fet = ((state_q == StIdle) && !q_full) || (state_q == StWait) ||
                          (state_q == StDrain);
    assign cap  = rdy && rdy_from_fet && instr_valid;
    assign miss = rdy && rdy_from_fet && !instr_valid;

    assign pc        = pc_q;
    assign out_valid = !q_empty;
    assign out_pc    = q_head.pc;
    assign out_instr = q_head.instr;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        q_push    = 1'b0;
        q_pop     = 1'b0;
        q_flush   = 1'b0;

        if (rdy) begin
            if (jump_flag) begin
                q_flush = 1'b1;
                // An in-flight fill must complete before the PC may move.
                if ((state_q == StWait) || (state_q == StDrain) || (state_q == StIdle && miss)) begin
                    pend_pc_d = align_pc(jump_pc);
                    state_d   = StDrain;
                end else begin
                    pc_d    = align_pc(jump_pc);
                    state_d = StIdle;
                end
            end else begin
                q_pop = out_valid && out_ready;
                unique case (state_q)
                    StIdle: begin
                        if (cap) begin
                            q_push = 1'b1;
                            pc_d   = pc_q + 32'd4;
                        end else if (miss) begin
                            state_d = StWait;
                        end
                    end
                    StWait: begin
                        if (cap) begin
                            q_push  = 1'b1;
                            pc_d    = pc_q + 32'd4;
                            state_d = StIdle;
                        end
                    end
                    StDrain: begin
                        if (cap) begin
                            pc_d    = pend_pc_q;
                            state_d = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pc_q      <= align_pc(RESET_PC);
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    fetcher_queue #(
        .Depth(IQ_DEPTH)
    ) u_queue (
        .clk_i  (clk),
        .rst_ni (rst),
        .push_i (q_push),
        .pop_i  (q_pop),
        .flush_i(q_flush),
        .data_i ('{pc: pc_q, instr: instr}),
        .data_o (q_head),
        .full_o (q_full),
        .empty_o(q_empty)
    );

endmodule
